// File: rtl/adc_spi_pkg.sv
// Shared definitions for the 8-channel 12-bit serial ADC link,
// used by both the converter-side responder and the ADC controller.
package adc_spi_pkg;

    localparam int DATA_W          = 12;
    localparam int NCH             = 8;
    localparam int FRAME_BITS      = 16;
    localparam int LEAD_ZEROS      = FRAME_BITS - DATA_W;
    localparam int CH_W            = $clog2(NCH);
    localparam int CNT_W           = $clog2(FRAME_BITS + 1);
    localparam int ADDR_RISE_FIRST = 3;
    localparam int ADDR_RISE_LAST  = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Serial frame for one channel: leading zeros followed by the sample, MSB first.
    function automatic logic [FRAME_BITS-1:0] frame_word(
        input logic [NCH*DATA_W-1:0] ch_data,
        input logic [CH_W-1:0]       ch
    );
        int idx;
        idx = int'(ch);
        return {{LEAD_ZEROS{1'b0}}, ch_data[idx*DATA_W +: DATA_W]};
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin, with a registered copy
// of the synchronized level that yields single-cycle rise/fall strobes.
module sync_edge_det #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // RESET_VAL lets idle-high pins (chip select) come out of reset without a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = chain[STAGES-1] & ~prev;
    assign fall  = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/adc_spi_responder.sv
// Converter-side model of the serial ADC: decodes the controller's SPI frame,
// captures the next channel address and shifts out 16-bit sample frames.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iSCLK,
    input  logic                  iCS_n,
    input  logic                  iDIN,
    input  logic [NCH*DATA_W-1:0] iCH_DATA,
    output logic                  oDOUT,
    output logic                  oDOUT_EN,
    output logic [CH_W-1:0]       oCH,
    output logic                  oFRAME_DONE,
    output logic                  oABORT
);

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] ADDR_FIRST = CNT_W'(ADDR_RISE_FIRST);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_RISE_LAST);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic din_level, din_rise, din_fall;

    state_t                state, state_n;
    logic [CNT_W-1:0]      rise_cnt, rise_cnt_n;
    logic [CNT_W-1:0]      fall_cnt, fall_cnt_n;
    logic [CNT_W-1:0]      rise_inc;
    logic [FRAME_BITS-1:0] shift, shift_n;
    logic [CH_W-1:0]       next_ch, next_ch_n;
    logic [CH_W-1:0]       ch, ch_n;
    logic                  frame_done, frame_done_n;
    logic                  abort, abort_n;
    logic                  dout, dout_en;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk      (iCLK),
        .rst_n    (iRST),
        .async_in (iSCLK),
        .level    (sclk_level),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk      (iCLK),
        .rst_n    (iRST),
        .async_in (iCS_n),
        .level    (cs_level),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // DIN goes through the same depth as SCLK so it stays aligned with the SCLK rise.
    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
        .clk      (iCLK),
        .rst_n    (iRST),
        .async_in (iDIN),
        .level    (din_level),
        .rise     (din_rise),
        .fall     (din_fall)
    );

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state      <= IDLE;
            rise_cnt   <= '0;
            fall_cnt   <= '0;
            shift      <= '0;
            next_ch    <= '0;
            ch         <= '0;
            frame_done <= 1'b0;
            abort      <= 1'b0;
        end else begin
            state      <= state_n;
            rise_cnt   <= rise_cnt_n;
            fall_cnt   <= fall_cnt_n;
            shift      <= shift_n;
            next_ch    <= next_ch_n;
            ch         <= ch_n;
            frame_done <= frame_done_n;
            abort      <= abort_n;
        end
    end

    always_comb begin
        state_n      = state;
        rise_cnt_n   = rise_cnt;
        fall_cnt_n   = fall_cnt;
        shift_n      = shift;
        next_ch_n    = next_ch;
        ch_n         = ch;
        frame_done_n = 1'b0;
        abort_n      = 1'b0;
        dout         = 1'b0;
        dout_en      = 1'b0;
        rise_inc     = rise_cnt + CNT_ONE;

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    shift_n    = frame_word(iCH_DATA, ch);
                    rise_cnt_n = '0;
                    fall_cnt_n = '0;
                    state_n    = ACTIVE;
                end
            end

            ACTIVE: begin
                dout_en = 1'b1;
                dout    = shift[FRAME_BITS-1];
                if (cs_rise) begin
                    state_n = IDLE;
                    // next_ch always equals ch at a frame start, so restoring it undoes a partial address.
                    if (rise_cnt != '0 && rise_cnt < CNT_FULL) begin
                        abort_n   = 1'b1;
                        next_ch_n = ch;
                    end
                end else if (sclk_rise && rise_cnt < CNT_FULL) begin
                    rise_cnt_n = rise_inc;
                    if (rise_inc >= ADDR_FIRST && rise_inc <= ADDR_LAST) begin
                        next_ch_n = {next_ch[CH_W-2:0], din_level};
                    end
                    if (rise_inc == CNT_FULL) begin
                        frame_done_n = 1'b1;
                        ch_n         = next_ch;
                    end
                end else if (sclk_fall && fall_cnt < CNT_FULL) begin
                    if (fall_cnt == CNT_LAST) begin
                        shift_n    = frame_word(iCH_DATA, ch);
                        rise_cnt_n = '0;
                        fall_cnt_n = '0;
                    end else begin
                        fall_cnt_n = fall_cnt + CNT_ONE;
                        shift_n    = {shift[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign oDOUT       = dout;
    assign oDOUT_EN    = dout_en;
    assign oCH         = ch;
    assign oFRAME_DONE = frame_done;
    assign oABORT      = abort;

endmodule
